// File: rtl/fwd_pkg.sv
// ============================================================================
// Module      : fwd_pkg
// Description : Shared types and constants for the forwarding scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fwd_pkg;

  localparam int FWD_DATA_W  = 16;
  localparam int FWD_RADDR_W = 4;
  localparam int REG_ZERO    = 0;

  localparam int STG_EX  = 0;
  localparam int STG_MEM = 1;
  localparam int STG_WB  = 2;

  typedef struct packed {
    logic                   valid;
    logic                   regwrite;
    logic                   is_load;
    logic [FWD_RADDR_W-1:0] rd;
  } fwd_entry_t;

  // A load's data only exists once it has reached the load-ready stage.
  function automatic logic entry_ready(input logic is_load, input int idx, input int load_rdy);
    return !is_load || (idx >= load_rdy);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fwd_src_lookup.sv
// ============================================================================
// Module      : fwd_src_lookup
// Description : Youngest-first producer scan for one source operand.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fwd_src_lookup
  import fwd_pkg::*;
#(
  parameter int DATA_W   = FWD_DATA_W,
  parameter int RADDR_W  = FWD_RADDR_W,
  parameter int DEPTH    = 3,
  parameter int LOAD_RDY = STG_WB
) (
  input  logic [RADDR_W-1:0]       addr,
  input  logic [DATA_W-1:0]        rf_data,
  input  logic [DEPTH-1:0]         ent_valid,
  input  logic [DEPTH-1:0]         ent_regwrite,
  input  logic [DEPTH-1:0]         ent_is_load,
  input  logic [DEPTH*RADDR_W-1:0] ent_rd,
  input  logic [DEPTH*DATA_W-1:0]  stage_result,
  output logic                     hit,
  output logic [1:0]               stage,
  output logic                     not_ready,
  output logic [DATA_W-1:0]        data
);

  logic              w_found;
  logic              w_ready;
  logic [1:0]        w_idx;
  logic [DATA_W-1:0] w_fwd;

  always_comb begin
    w_found = 1'b0;
    w_ready = 1'b0;
    w_idx   = 2'd0;
    w_fwd   = '0;
    if (addr != RADDR_W'(REG_ZERO)) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (!w_found && ent_valid[i] && ent_regwrite[i] &&
            (ent_rd[i*RADDR_W +: RADDR_W] == addr)) begin
          w_found = 1'b1;
          w_ready = entry_ready(ent_is_load[i], i, LOAD_RDY);
          w_idx   = 2'(i);
          w_fwd   = stage_result[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  assign hit       = w_found & w_ready;
  assign not_ready = w_found & ~w_ready;
  assign stage     = hit ? w_idx : 2'd0;
  assign data      = hit ? w_fwd : rf_data;

endmodule

`default_nettype wire

// File: rtl/fwd_scoreboard.sv
// ============================================================================
// Module      : fwd_scoreboard
// Description : In-flight write tracker with operand forwarding and load-use
//               stall. FWD_PERF_CNT_EN adds stall/forward performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fwd_scoreboard
  import fwd_pkg::*;
#(
  parameter int DATA_W     = FWD_DATA_W,
  parameter int RADDR_W    = FWD_RADDR_W,
  parameter int DEPTH      = 3,
  parameter int NUM_SRC    = 2,
  parameter int LOAD_RDY   = STG_WB,
  parameter int FLUSH_UPTO = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       advance,
  input  logic                       flush,
  input  logic                       issue_valid,
  input  logic                       issue_regwrite,
  input  logic                       issue_is_load,
  input  logic [RADDR_W-1:0]         issue_rd,
  input  logic [DEPTH*DATA_W-1:0]    stage_result,
  input  logic [NUM_SRC*RADDR_W-1:0] src_addr,
  input  logic [NUM_SRC*DATA_W-1:0]  src_rf_data,
  output logic [NUM_SRC*DATA_W-1:0]  src_data,
  output logic [NUM_SRC-1:0]         src_hit,
  output logic [NUM_SRC*2-1:0]       src_stage,
  output logic                       stall
`ifdef FWD_PERF_CNT_EN
  ,
  output logic [15:0]                stall_cnt,
  output logic [15:0]                fwd_cnt
`endif
);

  logic [DEPTH-1:0]         r_valid;
  logic [DEPTH-1:0]         r_regwrite;
  logic [DEPTH-1:0]         r_is_load;
  logic [DEPTH*RADDR_W-1:0] r_rd;

  logic [DEPTH-1:0]         w_nxt_valid;
  logic [DEPTH-1:0]         w_nxt_regwrite;
  logic [DEPTH-1:0]         w_nxt_is_load;
  logic [DEPTH*RADDR_W-1:0] w_nxt_rd;
  logic [NUM_SRC-1:0]       w_not_ready;
  logic                     w_take;

  generate
    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
      fwd_src_lookup #(
        .DATA_W   (DATA_W),
        .RADDR_W  (RADDR_W),
        .DEPTH    (DEPTH),
        .LOAD_RDY (LOAD_RDY)
      ) u_lookup (
        .addr         (src_addr[s*RADDR_W +: RADDR_W]),
        .rf_data      (src_rf_data[s*DATA_W +: DATA_W]),
        .ent_valid    (r_valid),
        .ent_regwrite (r_regwrite),
        .ent_is_load  (r_is_load),
        .ent_rd       (r_rd),
        .stage_result (stage_result),
        .hit          (src_hit[s]),
        .stage        (src_stage[s*2 +: 2]),
        .not_ready    (w_not_ready[s]),
        .data         (src_data[s*DATA_W +: DATA_W])
      );
    end
  endgenerate

  assign stall  = |w_not_ready;
  assign w_take = issue_valid & ~stall & ~flush;

  // Shift first, then squash the youngest entries of the shifted state.
  always_comb begin
    w_nxt_valid    = r_valid;
    w_nxt_regwrite = r_regwrite;
    w_nxt_is_load  = r_is_load;
    w_nxt_rd       = r_rd;
    if (advance) begin
      for (int i = DEPTH-1; i > 0; i--) begin
        w_nxt_valid[i]                    = r_valid[i-1];
        w_nxt_regwrite[i]                 = r_regwrite[i-1];
        w_nxt_is_load[i]                  = r_is_load[i-1];
        w_nxt_rd[i*RADDR_W +: RADDR_W]    = r_rd[(i-1)*RADDR_W +: RADDR_W];
      end
      w_nxt_valid[0]          = w_take;
      w_nxt_regwrite[0]       = w_take & issue_regwrite;
      w_nxt_is_load[0]        = w_take & issue_is_load;
      w_nxt_rd[0 +: RADDR_W]  = w_take ? issue_rd : '0;
    end
    if (flush) begin
      for (int i = 0; i < FLUSH_UPTO; i++) begin
        w_nxt_valid[i]                 = 1'b0;
        w_nxt_regwrite[i]              = 1'b0;
        w_nxt_is_load[i]               = 1'b0;
        w_nxt_rd[i*RADDR_W +: RADDR_W] = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid    <= '0;
      r_regwrite <= '0;
      r_is_load  <= '0;
      r_rd       <= '0;
    end else begin
      r_valid    <= w_nxt_valid;
      r_regwrite <= w_nxt_regwrite;
      r_is_load  <= w_nxt_is_load;
      r_rd       <= w_nxt_rd;
    end
  end

`ifdef FWD_PERF_CNT_EN
  logic [15:0] r_stall_cnt;
  logic [15:0] r_fwd_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_fwd_cnt   <= '0;
    end else if (advance) begin
      if (stall && (r_stall_cnt != 16'hFFFF)) r_stall_cnt <= r_stall_cnt + 16'd1;
      if ((|src_hit) && (r_fwd_cnt != 16'hFFFF)) r_fwd_cnt <= r_fwd_cnt + 16'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign fwd_cnt   = r_fwd_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fwd_scoreboard.sv
// ============================================================================
// Module      : tb_fwd_scoreboard
// Description : Directed vector bench for fwd_scoreboard (optional FWD_PERF_CNT_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fwd_scoreboard;

  localparam logic [15:0] c_a  = 16'hA000;
  localparam logic [15:0] c_b  = 16'hB111;
  localparam logic [15:0] c_c  = 16'hC222;
  localparam logic [15:0] c_r0 = 16'h1111;
  localparam logic [15:0] c_r1 = 16'h2222;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        advance, flush, issue_valid, issue_regwrite, issue_is_load;
  logic [3:0]  issue_rd;
  logic [47:0] stage_result;
  logic [7:0]  src_addr;
  logic [31:0] src_rf_data;
  logic [31:0] src_data;
  logic [1:0]  src_hit;
  logic [3:0]  src_stage;
  logic        stall;
`ifdef FWD_PERF_CNT_EN
  logic [15:0] stall_cnt, fwd_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fwd_scoreboard dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .advance        (advance),
    .flush          (flush),
    .issue_valid    (issue_valid),
    .issue_regwrite (issue_regwrite),
    .issue_is_load  (issue_is_load),
    .issue_rd       (issue_rd),
    .stage_result   (stage_result),
    .src_addr       (src_addr),
    .src_rf_data    (src_rf_data),
    .src_data       (src_data),
    .src_hit        (src_hit),
    .src_stage      (src_stage),
    .stall          (stall)
`ifdef FWD_PERF_CNT_EN
    ,
    .stall_cnt      (stall_cnt),
    .fwd_cnt        (fwd_cnt)
`endif
  );

  typedef struct {
    logic        adv, fl, iv, rw, ld;
    logic [3:0]  rd, a0, a1;
    logic [1:0]  hit, st0, st1;
    logic        stl;
    logic [15:0] d0, d1;
  } vec_t;

  vec_t vt[18];

  function automatic vec_t mk(input logic adv, fl, iv, rw, ld, input logic [3:0] rd, a0, a1,
                              input logic [1:0] hit, st0, st1, input logic stl,
                              input logic [15:0] d0, d1);
    vec_t v;
    v.adv = adv; v.fl = fl; v.iv = iv; v.rw = rw; v.ld = ld;
    v.rd = rd; v.a0 = a0; v.a1 = a1;
    v.hit = hit; v.st0 = st0; v.st1 = st1; v.stl = stl; v.d0 = d0; v.d1 = d1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic adv, fl, iv, rw, ld, input logic [3:0] rd, a0, a1);
    advance = adv; flush = fl; issue_valid = iv; issue_regwrite = rw; issue_is_load = ld;
    issue_rd = rd; src_addr = {a1, a0};
  endtask

  initial begin
    int exp_stall_cnt;
    int exp_fwd_cnt;
    // adv fl iv rw ld rd  a0 a1   hit   st0 st1 stall d0 d1
    vt[0]  = mk(1,0,1,1,0, 3,  3, 0, 2'b00, 0, 0, 0, c_r0, c_r1);
    vt[1]  = mk(1,0,1,1,1, 5,  3, 5, 2'b01, 0, 0, 0, c_a,  c_r1);
    vt[2]  = mk(1,0,1,1,0, 6,  3, 5, 2'b01, 1, 0, 1, c_b,  c_r1);
    vt[3]  = mk(1,0,1,1,0, 6,  3, 5, 2'b01, 2, 0, 1, c_c,  c_r1);
    vt[4]  = mk(1,0,1,1,0, 6,  3, 5, 2'b10, 0, 2, 0, c_r0, c_c);
    vt[5]  = mk(1,0,1,1,0, 4,  6, 0, 2'b01, 0, 0, 0, c_a,  c_r1);
    vt[6]  = mk(1,0,1,1,0, 4,  4, 6, 2'b11, 0, 1, 0, c_a,  c_b);
    vt[7]  = mk(1,0,1,1,0, 0,  4, 6, 2'b11, 0, 2, 0, c_a,  c_c);
    vt[8]  = mk(0,0,1,1,0, 7,  0, 4, 2'b10, 0, 1, 0, c_r0, c_b);
    vt[9]  = mk(1,1,1,1,0, 7,  0, 4, 2'b10, 0, 1, 0, c_r0, c_b);
    vt[10] = mk(1,0,1,1,0, 9,  4, 9, 2'b01, 2, 0, 0, c_c,  c_r1);
    vt[11] = mk(1,1,1,1,0, 10, 9, 0, 2'b01, 0, 0, 0, c_a,  c_r1);
    vt[12] = mk(1,0,1,1,0, 11, 10,9, 2'b10, 0, 1, 0, c_r0, c_b);
    vt[13] = mk(0,1,1,1,0, 12, 11,9, 2'b11, 0, 2, 0, c_a,  c_c);
    vt[14] = mk(0,0,1,1,0, 12, 11,9, 2'b10, 0, 2, 0, c_r0, c_c);
    vt[15] = mk(1,0,0,1,0, 12, 12,9, 2'b10, 0, 2, 0, c_r0, c_c);
    vt[16] = mk(1,0,1,0,0, 13, 12,9, 2'b00, 0, 0, 0, c_r0, c_r1);
    vt[17] = mk(1,0,1,1,0, 14, 13,0, 2'b00, 0, 0, 0, c_r0, c_r1);

    stage_result = {c_c, c_b, c_a};
    src_rf_data  = {c_r1, c_r0};
    rst_n = 1'b0;
    drive(0,0,0,0,0, 0, 3, 5);

    @(negedge clk);
    #2;
    chk("reset_stall", {31'd0, stall}, 32'd0);
    chk("reset_hit", {30'd0, src_hit}, 32'd0);
    chk("reset_data", src_data, {c_r1, c_r0});
    rst_n = 1'b1;

    exp_stall_cnt = 0;
    exp_fwd_cnt   = 0;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      drive(vt[i].adv, vt[i].fl, vt[i].iv, vt[i].rw, vt[i].ld, vt[i].rd, vt[i].a0, vt[i].a1);
      #2;
      chk($sformatf("v%0d_hit", i), {30'd0, src_hit}, {30'd0, vt[i].hit});
      chk($sformatf("v%0d_stage", i), {28'd0, src_stage}, {28'd0, vt[i].st1, vt[i].st0});
      chk($sformatf("v%0d_stall", i), {31'd0, stall}, {31'd0, vt[i].stl});
      chk($sformatf("v%0d_data", i), src_data, {vt[i].d1, vt[i].d0});
      if (vt[i].adv) begin
        exp_stall_cnt += int'(vt[i].stl);
        exp_fwd_cnt   += int'(|vt[i].hit);
      end
    end

    // Load issue, then a dependent source held without advancing: stall persists.
    @(negedge clk);
    drive(1,0,1,1,1, 5, 0, 0);
    #2;
    chk("ld_issue_stall", {31'd0, stall}, 32'd0);
`ifdef FWD_PERF_CNT_EN
    chk("stall_cnt", {16'd0, stall_cnt}, 32'(exp_stall_cnt));
    chk("fwd_cnt", {16'd0, fwd_cnt}, 32'(exp_fwd_cnt));
`endif
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      drive(0,0,0,0,0, 0, 5, 0);
      #2;
      chk($sformatf("hold_stall%0d", k), {31'd0, stall}, 32'd1);
      chk($sformatf("hold_hit%0d", k), {30'd0, src_hit}, 32'd0);
      chk($sformatf("hold_data%0d", k), src_data, {c_r1, c_r0});
    end

    // Asynchronous reset while stalled, away from any clock edge.
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_stall", {31'd0, stall}, 32'd0);
    chk("arst_hit", {30'd0, src_hit}, 32'd0);
`ifdef FWD_PERF_CNT_EN
    chk("arst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
    chk("arst_fwd_cnt", {16'd0, fwd_cnt}, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    chk("post_rst_stall", {31'd0, stall}, 32'd0);
    chk("post_rst_data", src_data, {c_r1, c_r0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
